// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and legal operand widths.
package adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned WidthMin = 2;
  localparam int unsigned WidthMax = 32;

endpackage

// File: rtl/full_adder_bit.sv
// Purely combinational 1-bit full adder cell.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, WIDTH cycles per addition.
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  if (WIDTH < WidthMin || WIDTH > WidthMax) begin : gen_width_check
    $error("serial_adder: WIDTH out of range");
  end

  state_e          state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] ps;
  logic             carry;
  logic [CntW-1:0]  cnt;
  logic             fa_sum;
  logic             fa_cout;

  // ps[0] is always shifted out before it could be observed.
  logic unused_ps_lsb;
  assign unused_ps_lsb = ps[0];

  full_adder_bit u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .cin(carry),
    .s  (fa_sum),
    .co (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StIdle;
      sa    <= '0;
      sb    <= '0;
      ps    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
      unique case (state)
        StIdle, StDone: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
            ps    <= '0;
            busy  <= 1'b1;
            state <= StRun;
          end else begin
            state <= StIdle;
          end
        end
        StRun: begin
          // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          ps    <= {fa_sum, ps[WIDTH-1:1]};
          carry <= fa_cout;
          sa    <= {1'b0, sa[WIDTH-1:1]};
          sb    <= {1'b0, sb[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (cnt == CntLast) begin
            sum   <= {fa_sum, ps[WIDTH-1:1]};
            cout  <= fa_cout;
            done  <= 1'b1;
            state <= StDone;
          end else begin
            busy <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
